// File: rtl/clock_divider_bank_if.sv
// rtl/clock_divider_bank_if.sv - configuration and divided-clock bundle for clock_divider_bank
interface clock_divider_bank_if #(
  parameter int NCH  = 4,
  parameter int HW   = 8,
  parameter int SELW = 2
);
  logic            sync;
  logic            cfg_we;
  logic [SELW-1:0] cfg_sel;
  logic [HW-1:0]   cfg_half;
  logic [HW-1:0]   cfg_rdata;
  logic [NCH-1:0]  clk_out;
  logic [NCH-1:0]  rise_tick;

  modport master (
    output sync, cfg_we, cfg_sel, cfg_half,
    input  cfg_rdata, clk_out, rise_tick
  );

  modport slave (
    input  sync, cfg_we, cfg_sel, cfg_half,
    output cfg_rdata, clk_out, rise_tick
  );
endinterface

// File: rtl/clock_divider_bank.sv
// rtl/clock_divider_bank.sv - NCH-channel programmable 50%-duty clock divider with tick and sync
module clock_divider_bank #(
  parameter int NCH          = 4,
  parameter int HW           = 8,
  parameter int SELW         = 2,
  parameter int DEFAULT_HALF = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  clock_divider_bank_if.slave  bus
);

  logic [HW-1:0]  r_cnt   [NCH];
  logic [HW-1:0]  r_h_act [NCH];
  logic [HW-1:0]  r_h_shd [NCH];
  logic [NCH-1:0] r_out;
  logic [NCH-1:0] r_tick;

  logic [HW-1:0]  w_cnt_nxt   [NCH];
  logic [HW-1:0]  w_h_act_nxt [NCH];
  logic [HW-1:0]  w_h_shd_nxt [NCH];
  logic [NCH-1:0] w_out_nxt;
  logic [NCH-1:0] w_tick_nxt;
  logic [NCH-1:0] w_hit;
  logic [HW-1:0]  w_rdata;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      // Out-of-range selects never match any channel, so such writes vanish.
      w_hit[i]       = bus.cfg_we && (bus.cfg_sel == SELW'(i));
      w_h_shd_nxt[i] = w_hit[i] ? bus.cfg_half : r_h_shd[i];
      w_cnt_nxt[i]   = r_cnt[i];
      w_out_nxt[i]   = r_out[i];
      w_tick_nxt[i]  = 1'b0;
      w_h_act_nxt[i] = r_h_act[i];
      if (bus.sync) begin
        w_cnt_nxt[i]   = '0;
        w_out_nxt[i]   = 1'b0;
        w_h_act_nxt[i] = w_h_shd_nxt[i];
      end else if (w_hit[i] && ((bus.cfg_half == '0) || (r_h_act[i] == '0))) begin
        w_cnt_nxt[i]   = '0;
        w_out_nxt[i]   = 1'b0;
        w_h_act_nxt[i] = bus.cfg_half;
      end else if (r_h_act[i] == '0) begin
        w_cnt_nxt[i] = '0;
        w_out_nxt[i] = 1'b0;
      end else if (r_cnt[i] == (r_h_act[i] - HW'(1))) begin
        w_cnt_nxt[i]  = '0;
        w_out_nxt[i]  = ~r_out[i];
        w_tick_nxt[i] = ~r_out[i];
        // Falling edge closes the period: only here may the half-period change.
        if (r_out[i]) begin
          w_h_act_nxt[i] = w_h_shd_nxt[i];
        end
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + HW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i]   <= '0;
        r_h_act[i] <= HW'(DEFAULT_HALF);
        r_h_shd[i] <= HW'(DEFAULT_HALF);
      end
      r_out  <= '0;
      r_tick <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i]   <= w_cnt_nxt[i];
        r_h_act[i] <= w_h_act_nxt[i];
        r_h_shd[i] <= w_h_shd_nxt[i];
      end
      r_out  <= w_out_nxt;
      r_tick <= w_tick_nxt;
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.cfg_sel == SELW'(i)) begin
        w_rdata = r_h_act[i];
      end
    end
  end

  assign bus.cfg_rdata = w_rdata;
  assign bus.clk_out   = r_out;
  assign bus.rise_tick = r_tick;

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb/tb_clock_divider_bank.sv - randomized check of clock_divider_bank against a phase-count model
module tb_clock_divider_bank;
  localparam int NCH          = 4;
  localparam int HW           = 8;
  localparam int SELW         = 3;
  localparam int DEFAULT_HALF = 1;

  logic clk;
  logic resetn;

  clock_divider_bank_if #(.NCH(NCH), .HW(HW), .SELW(SELW)) bus ();

  clock_divider_bank #(
    .NCH(NCH), .HW(HW), .SELW(SELW), .DEFAULT_HALF(DEFAULT_HALF)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_miss;

  // Model: per channel, the active half-period, the shadow, and edges elapsed in the current period.
  int m_h   [NCH];
  int m_shd [NCH];
  int m_ph  [NCH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_h[i]   = DEFAULT_HALF;
      m_shd[i] = DEFAULT_HALF;
      m_ph[i]  = 0;
    end
  endtask

  task automatic model_edge(input bit s, input bit we, input int sel, input int half);
    for (int i = 0; i < NCH; i++) begin
      bit hit;
      hit = we && (sel == i);
      if (hit) m_shd[i] = half;
      if (s) begin
        m_ph[i] = 0;
        m_h[i]  = m_shd[i];
      end else if (hit && (half == 0 || m_h[i] == 0)) begin
        m_h[i]  = half;
        m_ph[i] = 0;
      end else if (m_h[i] != 0) begin
        m_ph[i]++;
        if (m_ph[i] == 2 * m_h[i]) begin
          m_ph[i] = 0;
          m_h[i]  = m_shd[i];
        end
      end
    end
  endtask

  function automatic logic [NCH-1:0] exp_out();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = (m_h[i] != 0) && (m_ph[i] >= m_h[i]);
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_tick();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = (m_h[i] != 0) && (m_ph[i] == m_h[i]);
    return v;
  endfunction

  function automatic int exp_rdata(input int sel);
    return (sel < NCH) ? m_h[sel] : 0;
  endfunction

  task automatic compare_all(input string phase);
    chk({phase, ".clk_out"},   32'(bus.clk_out),   32'(exp_out()));
    chk({phase, ".rise_tick"}, 32'(bus.rise_tick), 32'(exp_tick()));
    chk({phase, ".cfg_rdata"}, 32'(bus.cfg_rdata), 32'(exp_rdata(int'(bus.cfg_sel))));
  endtask

  task automatic step(input string phase, input bit s, input bit we, input int sel, input int half);
    @(negedge clk);
    bus.sync     = s;
    bus.cfg_we   = we;
    bus.cfg_sel  = SELW'(sel);
    bus.cfg_half = HW'(half);
    @(posedge clk);
    model_edge(s, we, sel, half);
    #1;
    compare_all(phase);
  endtask

  task automatic idle(input string phase, input int n, input int sel);
    for (int k = 0; k < n; k++) step(phase, 1'b0, 1'b0, sel, 0);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    resetn       = 1'b0;
    bus.sync     = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_sel  = '0;
    bus.cfg_half = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all("reset");
    chk("reset.rdata_default", 32'(bus.cfg_rdata), 32'(DEFAULT_HALF));
    #2 resetn = 1'b1;

    idle("div2", 8, 0);

    step("ch1_wr", 1'b0, 1'b1, 1, 3);
    step("ch1_sync", 1'b1, 1'b0, 1, 0);
    idle("ch1_run", 14, 1);

    step("ch2_wr2_sync", 1'b1, 1'b1, 2, 2);
    idle("ch2_h2", 5, 2);
    step("ch2_wr5", 1'b0, 1'b1, 2, 5);
    idle("ch2_h5", 25, 2);

    step("ch3_wr3", 1'b0, 1'b1, 3, 3);
    step("ch3_sync", 1'b1, 1'b0, 3, 0);
    begin
      int budget;
      budget = 0;
      while (!exp_out()[3] && budget < 20) begin
        step("ch3_wait", 1'b0, 1'b0, 3, 0);
        budget++;
      end
      chk("ch3_rise_wait", 32'(exp_out()[3]), 32'd1);
    end
    step("ch3_stop", 1'b0, 1'b1, 3, 0);
    chk("ch3_stopped_low", 32'(bus.clk_out[3]), 32'd0);
    idle("ch3_held", 5, 3);
    step("ch3_restart", 1'b0, 1'b1, 3, 4);
    idle("ch3_h4", 10, 3);

    step("lcm_wr1", 1'b0, 1'b1, 1, 2);
    step("lcm_wr2", 1'b0, 1'b1, 2, 3);
    step("lcm_wr3", 1'b0, 1'b1, 3, 4);
    step("lcm_sync", 1'b1, 1'b0, 0, 0);
    idle("lcm_run", 26, 3);

    for (int k = 0; k < 2500; k++) begin
      bit s, we;
      int sel, half;
      s    = ($urandom_range(0, 39) == 0);
      we   = ($urandom_range(0, 7) == 0);
      sel  = $urandom_range(0, 7);
      half = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
      step("rand", s, we, sel, half);
    end

    step("sel5_wr", 1'b0, 1'b1, 5, 9);
    chk("sel5_rdata_zero", 32'(bus.cfg_rdata), 32'd0);
    step("pre_rst_wr", 1'b0, 1'b1, 0, 2);
    idle("pre_rst", 3, 0);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    chk("async_rst.clk_out", 32'(bus.clk_out), 32'd0);
    compare_all("async_rst");
    @(posedge clk);
    #2 resetn = 1'b1;
    idle("post_rst", 6, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
